price_feed_tx: RTL and testbench

Transmit end of the 16-bit price stream consumed by the indicator blocks (RSI and peers). It accepts asynchronous per-stock price updates from the market-data front end and coalesces them into one latest-value slot per stock. It then emits paced words {stock_id[1:0], price[13:0]} with a one-cycle enable strobe, arbitrating round-robin across the four stocks. An overwrite counter reports updates lost to coalescing.

---
 rtl/price_feed_tx_pkg.sv | 37 +++
 rtl/rr_arbiter4.sv | 21 ++
 rtl/price_feed_tx.sv | 85 ++++++++
 tb/tb_price_feed_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/price_feed_tx_pkg.sv
// Shared word format for the 16-bit price stream: field widths, positions and
// pack/unpack helpers used by the transmitter and the indicator blocks.
package price_feed_tx_pkg;

    localparam int STOCK_ID_W = 2;
    localparam int PRICE_W    = 14;
    localparam int WORD_W     = 16;
    localparam int NUM_STOCKS = 4;

    localparam int ID_LSB    = 14;
    localparam int PRICE_LSB = 0;

    typedef logic [STOCK_ID_W-1:0] stock_id_t;
    typedef logic [PRICE_W-1:0]    price_t;
    typedef logic [WORD_W-1:0]     word_t;

    typedef struct packed {
        stock_id_t stock_id;
        price_t    price;
    } price_word_t;

    function automatic word_t pack_word(input stock_id_t id, input price_t price);
        price_word_t w;
        w.stock_id = id;
        w.price    = price;
        return word_t'(w);
    endfunction

    function automatic stock_id_t word_stock_id(input word_t w);
        return w[ID_LSB +: STOCK_ID_W];
    endfunction

    function automatic price_t word_price(input word_t w);
        return w[PRICE_LSB +: PRICE_W];
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: grants the first request found searching
// upward from one past the last grant, wrapping around.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any_grant
);

    always_comb begin
        grant     = 2'd0;
        any_grant = |req;
        // Walk from farthest to nearest so the nearest request overrides.
        for (int i = 4; i >= 1; i--) begin
            if (req[2'(last + 2'(i))]) begin
                grant = 2'(last + 2'(i));
            end
        end
    end

endmodule

// File: rtl/price_feed_tx.sv
// Price stream transmitter: coalesces per-stock updates into latest-value slots
// and emits paced {stock_id, price} words with round-robin fairness.
module price_feed_tx
    import price_feed_tx_pkg::*;
#(
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    input  logic [STOCK_ID_W-1:0] upd_stock_id,
    input  logic [PRICE_W-1:0]    upd_price,
    input  logic                  tx_pause,
    output logic [WORD_W-1:0]     price_out,
    output logic                  enable_out,
    output logic [NUM_STOCKS-1:0] pending_out,
    output logic [CNT_W-1:0]      overwrite_cnt
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

    price_t                slot [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] pending;
    stock_id_t             rr_ptr;
    stock_id_t             grant;
    logic                  any_req;
    logic [7:0]            gap_cnt;
    logic                  launch;
    logic                  overwrite;
    logic [NUM_STOCKS-1:0] set_mask;
    logic [NUM_STOCKS-1:0] clr_mask;

    rr_arbiter4 u_arb (
        .req       (pending),
        .last      (rr_ptr),
        .grant     (grant),
        .any_grant (any_req)
    );

    always_comb begin
        launch    = (gap_cnt == 8'd0) && !tx_pause && any_req;
        set_mask  = upd_valid ? (4'b0001 << upd_stock_id) : 4'b0000;
        clr_mask  = launch ? (4'b0001 << grant) : 4'b0000;
        // A same-edge launch of the stock consumes the old value, so nothing is lost.
        overwrite = upd_valid && pending[upd_stock_id] && !(launch && (grant == upd_stock_id));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                slot[i] <= '0;
            end
            pending       <= '0;
            rr_ptr        <= 2'd3;
            gap_cnt       <= 8'd0;
            price_out     <= '0;
            enable_out    <= 1'b0;
            overwrite_cnt <= '0;
        end else begin
            if (upd_valid) begin
                slot[upd_stock_id] <= upd_price;
            end
            // Set wins over clear so a same-stock update on the launch edge stays pending.
            pending <= (pending & ~clr_mask) | set_mask;
            if (overwrite && (overwrite_cnt != '1)) begin
                overwrite_cnt <= overwrite_cnt + CNT_W'(1);
            end
            if (launch) begin
                price_out  <= pack_word(grant, slot[grant]);
                enable_out <= 1'b1;
                rr_ptr     <= grant;
                gap_cnt    <= GAP_LOAD;
            end else begin
                enable_out <= 1'b0;
                if (gap_cnt != 8'd0) begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
            end
        end
    end

    assign pending_out = pending;

endmodule

// File: tb/tb_price_feed_tx.sv
// Directed bench for price_feed_tx: one instance with GAP=1 and one with GAP=4,
// inputs driven on the falling edge, outputs checked on the falling edge.
module tb_price_feed_tx;

    logic        clk;
    logic        rst;

    logic        a_upd_valid;
    logic [1:0]  a_upd_stock_id;
    logic [13:0] a_upd_price;
    logic        a_tx_pause;
    logic [15:0] a_price_out;
    logic        a_enable_out;
    logic [3:0]  a_pending_out;
    logic [7:0]  a_overwrite_cnt;

    logic        b_upd_valid;
    logic [1:0]  b_upd_stock_id;
    logic [13:0] b_upd_price;
    logic        b_tx_pause;
    logic [15:0] b_price_out;
    logic        b_enable_out;
    logic [3:0]  b_pending_out;
    logic [7:0]  b_overwrite_cnt;

    int errors = 0;
    int checks = 0;

    price_feed_tx #(.GAP(1), .CNT_W(8)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .upd_valid     (a_upd_valid),
        .upd_stock_id  (a_upd_stock_id),
        .upd_price     (a_upd_price),
        .tx_pause      (a_tx_pause),
        .price_out     (a_price_out),
        .enable_out    (a_enable_out),
        .pending_out   (a_pending_out),
        .overwrite_cnt (a_overwrite_cnt)
    );

    price_feed_tx #(.GAP(4), .CNT_W(8)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .upd_valid     (b_upd_valid),
        .upd_stock_id  (b_upd_stock_id),
        .upd_price     (b_upd_price),
        .tx_pause      (b_tx_pause),
        .price_out     (b_price_out),
        .enable_out    (b_enable_out),
        .pending_out   (b_pending_out),
        .overwrite_cnt (b_overwrite_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [1:0] id, input logic [13:0] p, input logic pause);
        a_upd_valid    = v;
        a_upd_stock_id = id;
        a_upd_price    = p;
        a_tx_pause     = pause;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] id, input logic [13:0] p, input logic pause);
        b_upd_valid    = v;
        b_upd_stock_id = id;
        b_upd_price    = p;
        b_tx_pause     = pause;
    endtask

    initial begin
        rst = 1'b1;
        drive_a(1'b0, 2'd0, 14'd0, 1'b0);
        drive_b(1'b0, 2'd0, 14'd0, 1'b0);
        next_cycle();
        chk("reset_a_price", 32'(a_price_out), 32'h0);
        chk("reset_a_enable", 32'(a_enable_out), 32'h0);
        chk("reset_a_pending", 32'(a_pending_out), 32'h0);
        chk("reset_a_cnt", 32'(a_overwrite_cnt), 32'h0);
        rst = 1'b0;
        next_cycle();

        // Single update: stock 2 price 1234
        drive_a(1'b1, 2'd2, 14'd1234, 1'b0);
        next_cycle();
        chk("single_pending", 32'(a_pending_out), 32'h4);
        chk("single_no_early", 32'(a_enable_out), 32'h0);
        drive_a(1'b0, 2'd0, 14'd0, 1'b0);
        next_cycle();
        chk("single_enable", 32'(a_enable_out), 32'h1);
        chk("single_word", 32'(a_price_out), 32'h84D2);
        chk("single_pending_clr", 32'(a_pending_out), 32'h0);
        next_cycle();
        chk("single_one_strobe", 32'(a_enable_out), 32'h0);

        // Coalescing under pause: stock 1 gets 100, 101, 102
        drive_a(1'b1, 2'd1, 14'd100, 1'b1);
        next_cycle();
        drive_a(1'b1, 2'd1, 14'd101, 1'b1);
        next_cycle();
        drive_a(1'b1, 2'd1, 14'd102, 1'b1);
        next_cycle();
        chk("coal_cnt", 32'(a_overwrite_cnt), 32'h2);
        chk("coal_pending", 32'(a_pending_out), 32'h2);
        chk("coal_paused", 32'(a_enable_out), 32'h0);
        drive_a(1'b0, 2'd0, 14'd0, 1'b0);
        next_cycle();
        chk("coal_enable", 32'(a_enable_out), 32'h1);
        chk("coal_word", 32'(a_price_out), 32'h4066);
        chk("coal_pending_clr", 32'(a_pending_out), 32'h0);
        next_cycle();
        chk("coal_one_strobe", 32'(a_enable_out), 32'h0);

        // Same-stock collision: stock 0 has 500, 600 arrives on the launch edge
        drive_a(1'b1, 2'd0, 14'd500, 1'b0);
        next_cycle();
        drive_a(1'b1, 2'd0, 14'd600, 1'b0);
        next_cycle();
        chk("coll_enable1", 32'(a_enable_out), 32'h1);
        chk("coll_word1", 32'(a_price_out), 32'h01F4);
        chk("coll_pending", 32'(a_pending_out), 32'h1);
        chk("coll_cnt", 32'(a_overwrite_cnt), 32'h2);
        drive_a(1'b0, 2'd0, 14'd0, 1'b0);
        next_cycle();
        chk("coll_enable2", 32'(a_enable_out), 32'h1);
        chk("coll_word2", 32'(a_price_out), 32'h0258);
        chk("coll_pending_clr", 32'(a_pending_out), 32'h0);
        chk("coll_cnt_after", 32'(a_overwrite_cnt), 32'h2);

        // Async reset with pending=1111 and the gap counter running on the GAP=4 instance
        drive_b(1'b1, 2'd0, 14'd1, 1'b1);
        next_cycle();
        drive_b(1'b1, 2'd1, 14'd2, 1'b1);
        next_cycle();
        drive_b(1'b1, 2'd2, 14'd3, 1'b1);
        next_cycle();
        drive_b(1'b1, 2'd3, 14'd4, 1'b1);
        next_cycle();
        chk("rstb_pending_full", 32'(b_pending_out), 32'hF);
        drive_b(1'b0, 2'd0, 14'd0, 1'b0);
        next_cycle();
        chk("rstb_enable", 32'(b_enable_out), 32'h1);
        chk("rstb_word", 32'(b_price_out), 32'h0001);
        chk("rstb_pending", 32'(b_pending_out), 32'hE);
        #2 rst = 1'b1;
        #1;
        chk("async_b_price", 32'(b_price_out), 32'h0);
        chk("async_b_enable", 32'(b_enable_out), 32'h0);
        chk("async_b_pending", 32'(b_pending_out), 32'h0);
        chk("async_a_cnt", 32'(a_overwrite_cnt), 32'h0);
        chk("async_a_price", 32'(a_price_out), 32'h0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("post_rst_quiet_b", 32'({b_enable_out, b_pending_out}), 32'h0);
        end

        // Round-robin on GAP=1: all four pending, order 0,1,2,3 after reset
        drive_a(1'b1, 2'd3, 14'd40, 1'b1);
        next_cycle();
        drive_a(1'b1, 2'd2, 14'd30, 1'b1);
        next_cycle();
        drive_a(1'b1, 2'd1, 14'd20, 1'b1);
        next_cycle();
        drive_a(1'b1, 2'd0, 14'd10, 1'b1);
        next_cycle();
        chk("rr_pending", 32'(a_pending_out), 32'hF);
        drive_a(1'b0, 2'd0, 14'd0, 1'b0);
        next_cycle();
        chk("rr_word0", 32'({a_enable_out, a_price_out}), 32'h1000A);
        next_cycle();
        chk("rr_word1", 32'({a_enable_out, a_price_out}), 32'h14014);
        next_cycle();
        chk("rr_word2", 32'({a_enable_out, a_price_out}), 32'h1801E);
        next_cycle();
        chk("rr_word3", 32'({a_enable_out, a_price_out}), 32'h1C028);
        chk("rr_pending_clr", 32'(a_pending_out), 32'h0);
        next_cycle();
        chk("rr_done", 32'(a_enable_out), 32'h0);

        // Pacing on GAP=4: stocks 0 and 3 pending, strobes 4 cycles apart
        drive_b(1'b1, 2'd3, 14'd9, 1'b1);
        next_cycle();
        drive_b(1'b1, 2'd0, 14'd7, 1'b1);
        next_cycle();
        drive_b(1'b0, 2'd0, 14'd0, 1'b0);
        next_cycle();
        chk("pace_word0", 32'({b_enable_out, b_price_out}), 32'h10007);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("pace_gap_low", 32'(b_enable_out), 32'h0);
        end
        next_cycle();
        chk("pace_word1", 32'({b_enable_out, b_price_out}), 32'h1C009);
        chk("pace_pending_clr", 32'(b_pending_out), 32'h0);
        next_cycle();
        chk("pace_done", 32'(b_enable_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
